// File: rtl/linebuffer_kxk.sv
// linebuffer_kxk: KxK sliding-window line buffer (in: clk, rst async active-low, clken, valid_in, din, flush, dec_en, width, height; out: win, win_valid, cnt_col, cnt_row; sof/eof added when LB_FRAME_STATUS_EN is defined)
module linebuffer_kxk #(
  parameter int DW = 8,
  parameter int AW = 11,
  parameter int K = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clken,
  input  logic             valid_in,
  input  logic [DW-1:0]    din,
  input  logic             flush,
  input  logic             dec_en,
  input  logic [AW-1:0]    width,
  input  logic [AW-1:0]    height,
  output logic [K*K*DW-1:0] win,
  output logic             win_valid,
`ifdef LB_FRAME_STATUS_EN
  output logic             sof,
  output logic             eof,
`endif
  output logic [AW-1:0]    cnt_col,
  output logic [AW-1:0]    cnt_row
);
  localparam bit P = ((K - 1) % 2) == 1;
  logic acc, col_end, row_end, in_win;
  logic [AW-1:0] w_s, h_s;
  logic [DW-1:0] mem [K-1][2**AW];
  logic [DW-1:0] tap [K];
  logic [DW-1:0] wr [K][K];
  assign acc = clken & valid_in & ~flush;
  assign col_end = cnt_col == w_s - 1'b1;
  assign row_end = cnt_row == h_s - 1'b1;
  assign in_win = cnt_row >= AW'(K-1) && cnt_col >= AW'(K-1) &&
                  (!dec_en || (cnt_row[0] == P && cnt_col[0] == P));
  always_comb begin
    tap[K-1] = din;
    for (int i = 0; i < K-1; i++) tap[K-2-i] = mem[i][cnt_col];
  end
  always_ff @(posedge clk)
    if (acc) begin
      mem[0][cnt_col] <= din;
      for (int i = 1; i < K-1; i++) mem[i][cnt_col] <= mem[i-1][cnt_col];
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      w_s <= '0;
      h_s <= '0;
      cnt_col <= '0;
      cnt_row <= '0;
      win_valid <= 1'b0;
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++) wr[r][c] <= '0;
    end else begin
      win_valid <= acc & in_win;
      if (clken && cnt_col == '0 && cnt_row == '0) begin
        w_s <= width;
        h_s <= height;
      end
      if (clken && flush) begin
        cnt_col <= '0;
        cnt_row <= '0;
      end else if (acc) begin
        cnt_col <= col_end ? '0 : cnt_col + 1'b1;
        if (col_end) cnt_row <= row_end ? '0 : cnt_row + 1'b1;
        for (int r = 0; r < K; r++) begin
          for (int c = 0; c < K-1; c++) wr[r][c] <= wr[r][c+1];
          wr[r][K-1] <= tap[r];
        end
      end
    end
`ifdef LB_FRAME_STATUS_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sof <= 1'b0;
      eof <= 1'b0;
    end else begin
      sof <= acc && cnt_row == AW'(K-1) && cnt_col == AW'(K-1);
      eof <= acc && row_end && col_end;
    end
`endif
  for (genvar r = 0; r < K; r++) begin : g_r
    for (genvar c = 0; c < K; c++) begin : g_c
      assign win[(r*K+c)*DW +: DW] = wr[r][c];
    end
  end
endmodule

// File: tb/tb_linebuffer_kxk.sv
// tb_linebuffer_kxk: directed self-checking bench for linebuffer_kxk
module tb_linebuffer_kxk;
  localparam int DW = 8, AW = 11, K = 3;
  logic clk = 0, rst = 0, clken = 0, valid_in = 0, flush = 0, dec_en = 0;
  logic [DW-1:0] din = '0;
  logic [AW-1:0] width = 8, height = 6;
  logic [K*K*DW-1:0] win;
  logic win_valid;
  logic [AW-1:0] cnt_col, cnt_row;
`ifdef LB_FRAME_STATUS_EN
  logic sof, eof;
`endif
  int n_chk = 0, n_pass = 0, pulses = 0;
  always #5 clk = ~clk;
  always @(negedge clk) if (win_valid) pulses++;
  linebuffer_kxk #(.DW(DW), .AW(AW), .K(K)) dut (
    .clk(clk), .rst(rst), .clken(clken), .valid_in(valid_in), .din(din),
    .flush(flush), .dec_en(dec_en), .width(width), .height(height),
    .win(win), .win_valid(win_valid),
`ifdef LB_FRAME_STATUS_EN
    .sof(sof), .eof(eof),
`endif
    .cnt_col(cnt_col), .cnt_row(cnt_row)
  );
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic logic [K*K*DW-1:0] ew(input int r, input int c);
    ew = '0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        ew[(i*K+j)*DW +: DW] = DW'((r-K+1+i)*16 + (c-K+1+j));
  endfunction
  task automatic pix(input int r, input int c, input int w, input int h);
    bit ev, last;
    clken = 1;
    valid_in = 1;
    flush = 0;
    din = DW'(r*16 + c);
    @(posedge clk);
    #1;
    valid_in = 0;
    ev = r >= K-1 && c >= K-1 && (!dec_en || ((r-K+1)%2 == 0 && (c-K+1)%2 == 0));
    last = r == h-1 && c == w-1;
    check($sformatf("wv(%0d,%0d)", r, c), win_valid, ev);
    if (ev) check($sformatf("win(%0d,%0d)", r, c), win, ew(r, c));
    if (last) check("wrap", {cnt_row, cnt_col}, 0);
`ifdef LB_FRAME_STATUS_EN
    check($sformatf("sof(%0d,%0d)", r, c), sof, r == K-1 && c == K-1);
    check($sformatf("eof(%0d,%0d)", r, c), eof, last);
`endif
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      if ($urandom_range(0, 1) == 1) begin
        clken = 0;
        valid_in = 1;
      end else begin
        clken = 1;
        valid_in = 0;
      end
      din = DW'($urandom);
      @(posedge clk);
      #1;
      check("idle_wv", win_valid, 0);
`ifdef LB_FRAME_STATUS_EN
      check("idle_sof", sof, 0);
      check("idle_eof", eof, 0);
`endif
      clken = 1;
      valid_in = 0;
    end
  endtask
  task automatic frame(input int w, input int h, input bit stall, input int stop_r, input int stop_c,
                       input int chg_r, input int chg_c, input int chg_w);
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        if (r == stop_r && c == stop_c) return;
        if (r == chg_r && c == chg_c) width = AW'(chg_w);
        if (stall && $urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        pix(r, c, w, h);
      end
  endtask
  task automatic run(input string tag, input int w, input int h, input int exp_p, input bit stall = 0,
                     input int chg_r = -1, input int chg_c = -1, input int chg_w = 0);
    int p0;
    p0 = pulses;
    frame(w, h, stall, -1, -1, chg_r, chg_c, chg_w);
    @(negedge clk);
    #1;
    check(tag, pulses - p0, exp_p);
  endtask
  initial begin
    int p0;
    #8;
    check("rst_win", win, 0);
    check("rst_wv", win_valid, 0);
    check("rst_col", cnt_col, 0);
    check("rst_row", cnt_row, 0);
    #4 rst = 1;
    @(negedge clk);
    run("ramp_pulses", 8, 6, 24);
    dec_en = 1;
    run("dec_pulses", 8, 6, 6);
    dec_en = 0;
    run("stall_pulses", 8, 6, 24, 1);
    p0 = pulses;
    frame(8, 6, 0, 3, 5, -1, -1, 0);
    flush = 1;
    clken = 1;
    valid_in = 1;
    din = 8'h35;
    @(posedge clk);
    #1;
    flush = 0;
    valid_in = 0;
    check("flush_wv", win_valid, 0);
    check("flush_col", cnt_col, 0);
    check("flush_row", cnt_row, 0);
    check("flush_pre_pulses", pulses - p0, 9);
    run("post_flush_pulses", 8, 6, 24);
    run("cfg1_pulses", 8, 6, 24, 0, 1, 3, 10);
    run("cfg2_pulses", 10, 6, 32);
    width = 8;
    frame(8, 6, 0, 2, 4, -1, -1, 0);
    #3 rst = 0;
    #1;
    check("arst_col", cnt_col, 0);
    check("arst_row", cnt_row, 0);
    check("arst_wv", win_valid, 0);
    check("arst_win", win, 0);
    rst = 1;
    run("post_rst_pulses", 8, 6, 24);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
